// File: rtl/friscv_uart_pkg.sv
// Purpose : shared UART types and line-level constants for the TX and RX engines.
// Contents: uart_tx_state_t frame FSM encoding, idle/start line levels.
// Config  : none (the optional parity state is always encoded so TX and RX agree).
package friscv_uart_pkg;

  // Frame sequencing state. PARITY is only entered when the engine is built
  // with FRISCV_UART_TX_PARITY_EN, but the encoding is fixed regardless.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  // Line levels: a UART line rests high, and a frame opens with a low start bit.
  localparam logic UART_IDLE_LEVEL  = 1'b1;
  localparam logic UART_START_LEVEL = 1'b0;

endpackage : friscv_uart_pkg

// File: rtl/friscv_uart_baud_timer.sv
// Purpose : bit-period timer; latches a divider on load and pulses bit_tick once
//           every div cycles while run is high (divider 0 is treated as 1).
// Ports   : aclk/srst clock and sync active-high reset; load latches div and
//           restarts the count; run enables counting; bit_tick marks the last
//           cycle of each bit period (combinational from the count, single cycle).
// Config  : HALF_BIT_OFFSET preloads the count to div/2 so the first tick lands
//           mid-bit (receiver sampling); the transmitter leaves it at 0.
module friscv_uart_baud_timer #(
  parameter int CLK_DIV_W       = 32,
  parameter bit HALF_BIT_OFFSET = 1'b0
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 load,
  input  logic [CLK_DIV_W-1:0] div,
  input  logic                 run,
  output logic                 bit_tick
);

  localparam logic [CLK_DIV_W-1:0] DIV_ONE = {{(CLK_DIV_W-1){1'b0}}, 1'b1};

  logic [CLK_DIV_W-1:0] div_q;
  logic [CLK_DIV_W-1:0] cnt_q;
  logic [CLK_DIV_W-1:0] div_eff;
  logic [CLK_DIV_W-1:0] cnt_load;
  logic                 cnt_last;

  // A zero divider would never tick; clamp it to one cycle per bit.
  assign div_eff  = (div == '0) ? DIV_ONE : div;
  assign cnt_load = HALF_BIT_OFFSET ? (div_eff >> 1) : '0;

  // div_q is never zero (reset and load both keep it >= 1), so the
  // subtraction cannot wrap.
  assign cnt_last = (cnt_q == (div_q - DIV_ONE));
  assign bit_tick = run & cnt_last;

  always_ff @(posedge aclk) begin
    if (srst) begin
      div_q <= DIV_ONE;
      cnt_q <= '0;
    end else if (load) begin
      div_q <= div_eff;
      cnt_q <= cnt_load;
    end else if (run) begin
      cnt_q <= cnt_last ? '0 : (cnt_q + DIV_ONE);
    end else begin
      cnt_q <= '0;
    end
  end

endmodule : friscv_uart_baud_timer

// File: rtl/friscv_uart_tx_engine.sv
// Purpose : UART transmit serializer fed by the TX FIFO; pops one byte per frame
//           and sends start, DATA_W bits LSB first, [even parity], STOP_BITS stops.
// Ports   : aclk/srst clock and sync active-high reset; enable gates new frames;
//           clk_div cycles per bit (latched at accept); tx_valid/tx_ready/tx_data
//           FIFO pop handshake; busy frame in progress; uart_tx serial line.
// Config  : define FRISCV_UART_TX_PARITY_EN to insert an even-parity bit after DATA.
module friscv_uart_tx_engine
  import friscv_uart_pkg::*;
#(
  parameter int CLK_DIV_W = 32,
  parameter int DATA_W    = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                 aclk,
  input  logic                 srst,
  input  logic                 enable,
  input  logic [CLK_DIV_W-1:0] clk_div,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [7:0]           tx_data,
  output logic                 busy,
  output logic                 uart_tx
);

  localparam int BIT_CNT_W = 4;
  localparam logic [BIT_CNT_W-1:0] LAST_DATA_IDX = BIT_CNT_W'(DATA_W - 1);
  localparam logic [BIT_CNT_W-1:0] LAST_STOP_IDX = BIT_CNT_W'(STOP_BITS - 1);

  uart_tx_state_t        state_q, state_d;
  logic [DATA_W-1:0]     shift_q, shift_d;
  logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic                  uart_tx_q, uart_tx_d;
  logic                  busy_q, busy_d;
  logic                  accept;
  logic                  bit_tick;
  logic                  timer_run;
`ifdef FRISCV_UART_TX_PARITY_EN
  logic                  parity_q, parity_d;
`endif

  assign tx_ready  = enable & (state_q == IDLE) & ~srst;
  assign accept    = tx_valid & tx_ready;
  assign timer_run = (state_q != IDLE);

  // The divider is captured on accept, so clk_div writes during a frame only
  // affect the next one.
  friscv_uart_baud_timer #(
    .CLK_DIV_W       (CLK_DIV_W),
    .HALF_BIT_OFFSET (1'b0)
  ) u_baud_timer (
    .aclk     (aclk),
    .srst     (srst),
    .load     (accept),
    .div      (clk_div),
    .run      (timer_run),
    .bit_tick (bit_tick)
  );

  // Next-state, shift register and bit counter. bit_cnt is reused as the data
  // bit index in DATA and as the stop bit index in STOP.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
`ifdef FRISCV_UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = START;
          shift_d   = tx_data[DATA_W-1:0];
          bit_cnt_d = '0;
`ifdef FRISCV_UART_TX_PARITY_EN
          parity_d  = ^tx_data[DATA_W-1:0];
`endif
        end
      end
      START: begin
        if (bit_tick) begin
          state_d   = DATA;
          bit_cnt_d = '0;
        end
      end
      DATA: begin
        if (bit_tick) begin
          shift_d = shift_q >> 1;
          if (bit_cnt_q == LAST_DATA_IDX) begin
            bit_cnt_d = '0;
`ifdef FRISCV_UART_TX_PARITY_EN
            state_d   = PARITY;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
`ifdef FRISCV_UART_TX_PARITY_EN
      PARITY: begin
        if (bit_tick) begin
          state_d   = STOP;
          bit_cnt_d = '0;
        end
      end
`endif
      STOP: begin
        if (bit_tick) begin
          if (bit_cnt_q == LAST_STOP_IDX) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
    endcase
  end

  // Line level and busy are decoded from the next state and registered, so
  // both outputs change on the same edge as the state and have no
  // combinational path from the inputs.
  always_comb begin
    uart_tx_d = UART_IDLE_LEVEL;
    case (state_d)
      IDLE:   uart_tx_d = UART_IDLE_LEVEL;
      START:  uart_tx_d = UART_START_LEVEL;
      DATA:   uart_tx_d = shift_d[0];
`ifdef FRISCV_UART_TX_PARITY_EN
      PARITY: uart_tx_d = parity_d;
`endif
      STOP:   uart_tx_d = UART_IDLE_LEVEL;
      default: uart_tx_d = UART_IDLE_LEVEL;
    endcase
    busy_d = (state_d != IDLE);
  end

  // Reset drops any partial frame: the line returns high the following cycle.
  always_ff @(posedge aclk) begin
    if (srst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      uart_tx_q <= UART_IDLE_LEVEL;
      busy_q    <= 1'b0;
`ifdef FRISCV_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      uart_tx_q <= uart_tx_d;
      busy_q    <= busy_d;
`ifdef FRISCV_UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign uart_tx = uart_tx_q;
  assign busy    = busy_q;

endmodule : friscv_uart_tx_engine

// File: tb/tb_friscv_uart_tx_engine.sv
// Purpose : self-checking bench for friscv_uart_tx_engine; a scoreboard queue
//           holds the expected line level for every busy cycle of each frame.
// Ports   : none (top level); drives inputs just after posedge, samples at negedge.
// Config  : honours FRISCV_UART_TX_PARITY_EN for the frame model and parity test.
module tb_friscv_uart_tx_engine;

  localparam int DATA_W    = 8;
  localparam int STOP_BITS = 1;
`ifdef FRISCV_UART_TX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif
  localparam int FRAME_BITS = 1 + DATA_W + PAR_BITS + STOP_BITS;
  localparam int TIMEOUT    = 5000;

  logic        aclk;
  logic        srst;
  logic        enable;
  logic [31:0] clk_div;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  tx_data;
  logic        busy;
  logic        uart_tx;

  friscv_uart_tx_engine #(
    .CLK_DIV_W (32),
    .DATA_W    (DATA_W),
    .STOP_BITS (STOP_BITS)
  ) dut (
    .aclk     (aclk),
    .srst     (srst),
    .enable   (enable),
    .clk_div  (clk_div),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .busy     (busy),
    .uart_tx  (uart_tx)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  bit   mon_en      = 1'b0;
  logic exp_q[$];
  int   acc_cyc[$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Scoreboard: compare this cycle's line against the queue head, then, if a
  // byte will be accepted at the coming edge, push its whole frame.
  always @(negedge aclk) begin : monitor
    logic       e;
    int         d;
    logic [7:0] b;
    if (mon_en) begin
      vectors++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        if (busy !== 1'b1 || uart_tx !== e) begin
          miscompares++;
          $display("FAIL frame_bit cyc=%0d got busy=%b uart_tx=%b want busy=1 uart_tx=%b",
                   cyc, busy, uart_tx, e);
        end
      end else if (busy !== 1'b0 || uart_tx !== 1'b1) begin
        miscompares++;
        $display("FAIL idle_line cyc=%0d got busy=%b uart_tx=%b want busy=0 uart_tx=1",
                 cyc, busy, uart_tx);
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
        d = (clk_div == 32'd0) ? 1 : int'(clk_div);
        b = tx_data;
        acc_cyc.push_back(cyc);
        for (int k = 0; k < FRAME_BITS; k++) begin
          if (k == 0)           e = 1'b0;
          else if (k <= DATA_W) e = b[k-1];
          else if (k == DATA_W + 1 && PAR_BITS == 1) e = ^b;
          else                  e = 1'b1;
          for (int r = 0; r < d; r++) exp_q.push_back(e);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // Offers a byte and holds it until accepted; returns just after that edge.
  task automatic push_byte(input logic [7:0] b);
    bit ok;
    ok       = 1'b0;
    tx_data  = b;
    tx_valid = 1'b1;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge aclk);
      if (tx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk); #1;
    tx_valid = 1'b0;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL push_timeout data=%h got no tx_ready want accept", b);
    end
  endtask

  // Waits for the scoreboard to drain and the engine to go idle.
  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge aclk);
      if (exp_q.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge aclk); #1;
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL idle_timeout got busy=%b pending=%0d want idle", busy, exp_q.size());
    end
  endtask

  task automatic test_reset();
    srst     = 1'b1;
    enable   = 1'b1;
    clk_div  = 32'd4;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) begin
      @(negedge aclk);
      vectors++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_hold got uart_tx=%b busy=%b tx_ready=%b want 1 0 0",
                 uart_tx, busy, tx_ready);
      end
    end
    mon_en = 1'b1;
    @(posedge aclk); #1;
    srst = 1'b0;
    @(negedge aclk);
    vectors++;
    if (tx_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready got tx_ready=%b want 1", tx_ready);
    end
    @(posedge aclk); #1;
  endtask

  task automatic test_single();
    int n;
    clk_div = 32'd4;
    push_byte(8'h55);
    n = 0;
    for (int i = 0; i < TIMEOUT; i++) begin
      @(negedge aclk);
      if (busy === 1'b1) n++;
      else break;
    end
    vectors++;
    if (n != 4 * FRAME_BITS) begin
      miscompares++;
      $display("FAIL single_busy_len got %0d cycles want %0d", n, 4 * FRAME_BITS);
    end
    @(posedge aclk); #1;
    wait_idle();
  endtask

  task automatic test_back_to_back();
    acc_cyc.delete();
    clk_div = 32'd2;
    push_byte(8'hA3);
    push_byte(8'h0F);
    wait_idle();
    vectors++;
    if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != 2 * FRAME_BITS + 1) begin
      miscompares++;
      $display("FAIL b2b_gap got accepts=%0d spacing=%0d want 2 spacing=%0d", acc_cyc.size(),
               (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, 2 * FRAME_BITS + 1);
    end
  endtask

  task automatic test_div_edge();
    acc_cyc.delete();
    clk_div = 32'd0;
    push_byte(8'hFF);
    clk_div = 32'd8;
    push_byte(8'h5A);
    wait_idle();
    vectors++;
    if (acc_cyc.size() != 2 || (acc_cyc[1] - acc_cyc[0]) != FRAME_BITS + 1) begin
      miscompares++;
      $display("FAIL div0_frame_len got accepts=%0d spacing=%0d want 2 spacing=%0d", acc_cyc.size(),
               (acc_cyc.size() == 2) ? acc_cyc[1] - acc_cyc[0] : -1, FRAME_BITS + 1);
    end
  endtask

  task automatic test_enable_drop();
    int rdy_seen;
    clk_div = 32'd4;
    push_byte(8'hC6);
    // Accept edge plus 16 more edges lands in the first cycle of data bit 3.
    repeat (16) @(posedge aclk);
    #1;
    enable   = 1'b0;
    tx_data  = 8'h99;
    tx_valid = 1'b1;
    wait_idle();
    rdy_seen = 0;
    repeat (8) begin
      @(negedge aclk);
      if (tx_ready !== 1'b0) rdy_seen++;
    end
    vectors++;
    if (rdy_seen != 0) begin
      miscompares++;
      $display("FAIL enable_off_ready got %0d ready cycles want 0", rdy_seen);
    end
    @(posedge aclk); #1;
    enable = 1'b1;
    push_byte(8'h99);
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int low_seen;
    clk_div = 32'd4;
    push_byte(8'hC6);
    repeat (16) @(posedge aclk);
    #1;
    srst = 1'b1;
    // Only the current cycle of data bit 3 remains visible before reset lands.
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge aclk);
    vectors++;
    if (tx_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_ready got tx_ready=%b want 0", tx_ready);
    end
    @(posedge aclk); #1;
    srst = 1'b0;
    @(negedge aclk);
    vectors++;
    if (uart_tx !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid_line got uart_tx=%b busy=%b want 1 0", uart_tx, busy);
    end
    low_seen = 0;
    repeat (4 * FRAME_BITS) begin
      @(negedge aclk);
      if (uart_tx !== 1'b1) low_seen++;
    end
    vectors++;
    if (low_seen != 0) begin
      miscompares++;
      $display("FAIL reset_mid_tail got %0d non-idle cycles want 0", low_seen);
    end
    @(posedge aclk); #1;
  endtask

`ifdef FRISCV_UART_TX_PARITY_EN
  task automatic test_parity();
    logic [7:0] pat [2];
    logic       par [2];
    pat[0] = 8'h07; par[0] = 1'b1;
    pat[1] = 8'h03; par[1] = 1'b0;
    clk_div = 32'd3;
    for (int p = 0; p < 2; p++) begin
      push_byte(pat[p]);
      // Parity bit occupies cycles 28..30 after accept; sample cycle 29.
      repeat (28) @(posedge aclk);
      @(negedge aclk);
      vectors++;
      if (uart_tx !== par[p]) begin
        miscompares++;
        $display("FAIL parity_bit data=%h got %b want %b", pat[p], uart_tx, par[p]);
      end
      wait_idle();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_div_edge();
    test_enable_drop();
    test_reset_mid();
`ifdef FRISCV_UART_TX_PARITY_EN
    test_parity();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_friscv_uart_tx_engine
